// File: rtl/tg_operand_sequencer.sv
`timescale 1ns/1ps
// tg_operand_sequencer
//  Operand source and result sink for one threadgroup of four FEDPs
//  (2 weight groups x 2 activation groups). Collects K_STEPS operand chunks
//  per output tile. Each FEDP result is fed back as the partial sum of the
//  next chunk, and the partial sums are zeroed on the first chunk. The four
//  16-bit accumulated results are then presented on a valid/ready port.
//
//  Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         operand chunk handshake
//   in_weight0/1, in_act0/1   4 x int8 per word, byte0 = element 0
//   tg_weight_group0/1,
//   tg_activation_group0/1    registered operand words to the threadgroup
//   tg_partial_sum0..3        signed partial sums to FEDP0..3
//   tg_result0..3             signed FEDP0..3 results
//   out_valid/out_ready       tile result handshake
//   out_result                {acc3,acc2,acc1,acc0}
//   busy                      high whenever not idle
module tg_operand_sequencer #(
  parameter int K_STEPS  = 4,
  parameter int FEDP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic        [31:0] in_weight0,
  input  logic        [31:0] in_weight1,
  input  logic        [31:0] in_act0,
  input  logic        [31:0] in_act1,
  output logic        [31:0] tg_weight_group0,
  output logic        [31:0] tg_weight_group1,
  output logic        [31:0] tg_activation_group0,
  output logic        [31:0] tg_activation_group1,
  output logic signed [15:0] tg_partial_sum0,
  output logic signed [15:0] tg_partial_sum1,
  output logic signed [15:0] tg_partial_sum2,
  output logic signed [15:0] tg_partial_sum3,
  input  logic signed [15:0] tg_result0,
  input  logic signed [15:0] tg_result1,
  input  logic signed [15:0] tg_result2,
  input  logic signed [15:0] tg_result3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [63:0] out_result,
  output logic               busy
);

  localparam int STEP_W = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam int WAIT_W = $clog2(FEDP_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, NEXT, DONE} state_t;

  state_t             state, state_nxt;
  logic [STEP_W-1:0]  step_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic signed [15:0] acc0, acc1, acc2, acc3;
  logic               accept;
  logic               capture;
  logic               last_step;

  assign in_ready   = (state == IDLE) || (state == NEXT);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  // Results of the chunk loaded FEDP_LAT edges ago are valid on this edge.
  assign capture    = (state == WAIT) && (wait_cnt == WAIT_W'(FEDP_LAT - 1));
  assign last_step  = (step_cnt == STEP_W'(K_STEPS - 1));
  assign out_result = {acc3, acc2, acc1, acc0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = WAIT;
      WAIT: if (capture) state_nxt = last_step ? DONE : NEXT;
      NEXT: if (accept) state_nxt = WAIT;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      step_cnt             <= '0;
      wait_cnt             <= '0;
      tg_weight_group0     <= '0;
      tg_weight_group1     <= '0;
      tg_activation_group0 <= '0;
      tg_activation_group1 <= '0;
      tg_partial_sum0      <= '0;
      tg_partial_sum1      <= '0;
      tg_partial_sum2      <= '0;
      tg_partial_sum3      <= '0;
      acc0                 <= '0;
      acc1                 <= '0;
      acc2                 <= '0;
      acc3                 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            tg_weight_group0     <= in_weight0;
            tg_weight_group1     <= in_weight1;
            tg_activation_group0 <= in_act0;
            tg_activation_group1 <= in_act1;
            tg_partial_sum0      <= '0;
            tg_partial_sum1      <= '0;
            tg_partial_sum2      <= '0;
            tg_partial_sum3      <= '0;
            step_cnt             <= '0;
            wait_cnt             <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (capture) begin
            acc0 <= tg_result0;
            acc1 <= tg_result1;
            acc2 <= tg_result2;
            acc3 <= tg_result3;
          end
        end
        NEXT: begin
          // Previous chunk's results become this chunk's partial sums.
          if (accept) begin
            tg_weight_group0     <= in_weight0;
            tg_weight_group1     <= in_weight1;
            tg_activation_group0 <= in_act0;
            tg_activation_group1 <= in_act1;
            tg_partial_sum0      <= acc0;
            tg_partial_sum1      <= acc1;
            tg_partial_sum2      <= acc2;
            tg_partial_sum3      <= acc3;
            step_cnt             <= step_cnt + STEP_W'(1);
            wait_cnt             <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tg_operand_sequencer.sv
`timescale 1ns/1ps
module tb_tg_operand_sequencer;

  localparam int K0 = 2, L0 = 1;  // instance 0
  localparam int K1 = 1, L1 = 2;  // instance 1

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic        out_ready [2];
  logic        out_valid [2];
  logic        busy [2];
  logic [31:0] w0 [2], w1 [2], a0 [2], a1 [2];
  logic [31:0] tgw0 [2], tgw1 [2], tga0 [2], tga1 [2];
  logic [15:0] ps [2][4];
  logic [15:0] f0 [4], f1 [4], r1 [4];
  logic [63:0] out_result [2];
  int          mode [2];   // out_ready: 0 random, 1 low, 2 high
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;
  logic [63:0] q0 [$], q1 [$];
  logic [15:0] racc [2][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] dot4(input logic [31:0] w, input logic [31:0] a);
    int s;
    logic signed [7:0] wb, ab;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      wb = w[8*i +: 8];
      ab = a[8*i +: 8];
      s += int'(wb) * int'(ab);
    end
    return s[15:0];
  endfunction

  // Behavioural threadgroup: FEDP n pairs weight group n/2 with activation group n%2.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      f0[n] = dot4((n < 2) ? tgw0[0] : tgw1[0], (n % 2 == 0) ? tga0[0] : tga1[0]) + ps[0][n];
      f1[n] = dot4((n < 2) ? tgw0[1] : tgw1[1], (n % 2 == 0) ? tga0[1] : tga1[1]) + ps[1][n];
    end
  end
  always @(posedge clk) for (int n = 0; n < 4; n++) r1[n] <= f1[n];

  tg_operand_sequencer #(.K_STEPS(K0), .FEDP_LAT(L0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_weight0(w0[0]), .in_weight1(w1[0]), .in_act0(a0[0]), .in_act1(a1[0]),
    .tg_weight_group0(tgw0[0]), .tg_weight_group1(tgw1[0]),
    .tg_activation_group0(tga0[0]), .tg_activation_group1(tga1[0]),
    .tg_partial_sum0(ps[0][0]), .tg_partial_sum1(ps[0][1]),
    .tg_partial_sum2(ps[0][2]), .tg_partial_sum3(ps[0][3]),
    .tg_result0(f0[0]), .tg_result1(f0[1]), .tg_result2(f0[2]), .tg_result3(f0[3]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .busy(busy[0]));

  tg_operand_sequencer #(.K_STEPS(K1), .FEDP_LAT(L1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_weight0(w0[1]), .in_weight1(w1[1]), .in_act0(a0[1]), .in_act1(a1[1]),
    .tg_weight_group0(tgw0[1]), .tg_weight_group1(tgw1[1]),
    .tg_activation_group0(tga0[1]), .tg_activation_group1(tga1[1]),
    .tg_partial_sum0(ps[1][0]), .tg_partial_sum1(ps[1][1]),
    .tg_partial_sum2(ps[1][2]), .tg_partial_sum3(ps[1][3]),
    .tg_result0(r1[0]), .tg_result1(r1[1]), .tg_result2(r1[2]), .tg_result3(r1[3]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_result[1]), .busy(busy[1]));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endfunction

  // out_ready changes just after the rising edge, stable for sampling.
  initial begin
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        out_ready[d] = (mode[d] == 2) ? 1'b1 : (mode[d] == 1) ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  task automatic monitor(input int d);
    logic [63:0] held, exp;
    bit held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid[d]) begin
        held_v = 0;
      end else begin
        if (held_v) chk($sformatf("stable%0d", d), out_result[d], held);
        if (out_ready[d]) begin
          held_v = 0;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_out%0d", d), {63'd0, out_valid[d]}, 64'd0);
          end else begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("tile%0d", d), out_result[d], exp);
          end
        end else begin
          held_v = 1;
          held = out_result[d];
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic chk_reset(input int d);
    chk("rst_tg", {tgw0[d], tgw1[d]} | {tga0[d], tga1[d]}, 64'd0);
    chk("rst_ps", {ps[d][3], ps[d][2], ps[d][1], ps[d][0]}, 64'd0);
    chk("rst_out", out_result[d], 64'd0);
    chk("rst_ctl", {out_valid[d], busy[d], in_ready[d]}, 64'b001);
  endtask

  // Sends one tile; called and returns on a falling edge.
  task automatic send_tile(input int d, input bit rnd,
                           input logic [31:0] fx0, input logic [31:0] fx1,
                           input logic [31:0] fy0, input logic [31:0] fy1,
                           input int gap, output logic [63:0] seen);
    int kn, ln, t0, wt;
    logic [31:0] x0, x1, y0, y1;
    kn = (d == 0) ? K0 : K1;
    ln = (d == 0) ? L0 : L1;
    seen = '0;
    t0 = 0;
    for (int k = 0; k < kn; k++) begin
      x0 = rnd ? $urandom : fx0;
      x1 = rnd ? $urandom : fx1;
      y0 = rnd ? $urandom : fy0;
      y1 = rnd ? $urandom : fy1;
      w0[d] = x0; w1[d] = x1; a0[d] = y0; a1[d] = y1;
      in_valid[d] = 1'b1;
      wt = 0;
      while (!in_ready[d] && wt < 100) begin
        @(negedge clk);
        wt++;
      end
      if (!in_ready[d]) begin
        timeout("accept");
        in_valid[d] = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      if (k == 0) begin
        t0 = cyc;
        for (int n = 0; n < 4; n++) racc[d][n] = '0;
      end
      chk("tg_w", {tgw1[d], tgw0[d]}, {x1, x0});
      chk("tg_a", {tga1[d], tga0[d]}, {y1, y0});
      chk("tg_ps", {ps[d][3], ps[d][2], ps[d][1], ps[d][0]},
          {racc[d][3], racc[d][2], racc[d][1], racc[d][0]});
      racc[d][0] = racc[d][0] + dot4(x0, y0);
      racc[d][1] = racc[d][1] + dot4(x0, y1);
      racc[d][2] = racc[d][2] + dot4(x1, y0);
      racc[d][3] = racc[d][3] + dot4(x1, y1);
      if (k < kn - 1) begin
        // Let the sequencer reach NEXT, then stall with junk on the inputs.
        wt = 0;
        while (!in_ready[d] && wt < 100) begin
          @(negedge clk);
          wt++;
        end
        for (int g = 0; g < gap; g++) begin
          w0[d] = $urandom; w1[d] = $urandom; a0[d] = $urandom; a1[d] = $urandom;
          @(negedge clk);
          chk("gap_tg", {tgw1[d], tgw0[d], tga1[d], tga0[d]}, {x1, x0, y1, y0});
          chk("gap_ctl", {in_ready[d], busy[d], out_valid[d]}, 64'b110);
        end
      end
    end
    if (d == 0) q0.push_back({racc[0][3], racc[0][2], racc[0][1], racc[0][0]});
    else        q1.push_back({racc[1][3], racc[1][2], racc[1][1], racc[1][0]});
    wt = 0;
    while (!out_valid[d] && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    if (!out_valid[d]) begin
      timeout("out_valid");
    end else begin
      seen = out_result[d];
      if (gap == 0) chk("latency", 64'(cyc - t0), 64'(kn * (ln + 1) - 1));
    end
  endtask

  initial begin
    logic [63:0] seen;
    int wt;
    rst = 1'b1;
    mode[0] = 0; mode[1] = 0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      w0[d] = '0; w1[d] = '0; a0[d] = '0; a1[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset(0);

    // Two identical chunks: 4*1*2 per chunk.
    send_tile(0, 0, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202, 0, seen);
    chk("t1_result", seen, 64'h0010_0010_0010_0010);
    // Signed: 4 * (-1 * 127) = -508.
    send_tile(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, seen);
    chk("t2_signed", seen, 64'hFE04_FE04_FE04_FE04);
    // Cross-group mapping.
    send_tile(1, 0, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0, seen);
    chk("t6_mapping", seen, 64'h0020_0018_0010_000C);

    // Backpressure in DONE.
    mode[0] = 1;
    send_tile(0, 1, '0, '0, '0, '0, 0, seen);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ctl", {out_valid[0], in_ready[0], busy[0]}, 64'b101);
      chk("bp_hold", out_result[0], seen);
    end
    mode[0] = 2;
    @(negedge clk);
    chk("bp_still_valid", {63'd0, out_valid[0]}, 64'd1);
    @(negedge clk);
    chk("bp_release", {out_valid[0], in_ready[0], busy[0]}, 64'b010);
    mode[0] = 0;

    // Gapped input gives the same result as the unbroken tile.
    send_tile(0, 0, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202, 3, seen);
    chk("t4_gap_result", seen, 64'h0010_0010_0010_0010);

    // Reset during the first chunk's wait.
    w0[0] = 32'h05050505; w1[0] = 32'h06060606; a0[0] = 32'h07070707; a1[0] = 32'h08080808;
    in_valid[0] = 1'b1;
    wt = 0;
    while (!in_ready[0] && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    @(posedge clk);
    #2;
    chk("t5_in_wait", {in_ready[0], busy[0]}, 64'b01);
    rst = 1'b1;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    chk_reset(0);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle", {busy[0], in_ready[0]}, 64'b01);
    send_tile(0, 0, 32'h01010101, 32'h01010101, 32'h02020202, 32'h02020202, 0, seen);
    chk("t5_after_reset", seen, 64'h0010_0010_0010_0010);

    // Randomized traffic on both instances.
    for (int i = 0; i < 30; i++)
      send_tile($urandom_range(1), 1, '0, '0, '0, '0, $urandom_range(2), seen);

    wt = 0;
    while ((q0.size() != 0 || q1.size() != 0) && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    if (q0.size() != 0 || q1.size() != 0) timeout("drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
